// File: rtl/alu_issue.sv
// alu_issue: execute-stage issue buffer that drives an external ALU and owns NZCV.
// Optional overflow trap on add/sub: define ALU_ISSUE_OVF_TRAP_EN.
module alu_issue #(
  parameter logic [3:0] RESET_FLAGS = 4'b0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [3:0]  in_cond,
  input  logic [3:0]  in_opcode,
  input  logic        in_s,
  input  logic [3:0]  in_rd,
  input  logic [31:0] in_rn_val,
  input  logic [31:0] in_op2_val,
  output logic [31:0] alu_in_0,
  output logic [31:0] alu_in_1,
  output logic [3:0]  alu_op,
  input  logic [31:0] alu_out,
  input  logic        alu_of,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic [3:0]  out_rd,
  output logic        out_wr_en,
  output logic        out_undef,
  output logic [3:0]  flags
);

  localparam logic [3:0] ALU_OP_NOP  = 4'd0;
  localparam logic [3:0] ALU_OP_AND  = 4'd1;
  localparam logic [3:0] ALU_OP_OR   = 4'd2;
  localparam logic [3:0] ALU_OP_XOR  = 4'd3;
  localparam logic [3:0] ALU_OP_ADDS = 4'd4;
  localparam logic [3:0] ALU_OP_SUBS = 4'd5;

  localparam logic [3:0] OPC_AND = 4'h0;
  localparam logic [3:0] OPC_EOR = 4'h1;
  localparam logic [3:0] OPC_SUB = 4'h2;
  localparam logic [3:0] OPC_RSB = 4'h3;
  localparam logic [3:0] OPC_ADD = 4'h4;
  localparam logic [3:0] OPC_TST = 4'h8;
  localparam logic [3:0] OPC_TEQ = 4'h9;
  localparam logic [3:0] OPC_CMP = 4'ha;
  localparam logic [3:0] OPC_CMN = 4'hb;
  localparam logic [3:0] OPC_ORR = 4'hc;
  localparam logic [3:0] OPC_MOV = 4'hd;

  logic        out_valid_q, out_valid_d;
  logic [31:0] out_data_q, out_data_d;
  logic [3:0]  out_rd_q, out_rd_d;
  logic        out_wr_en_q, out_wr_en_d;
  logic        out_undef_q, out_undef_d;
  logic [3:0]  flags_q, flags_d;

  logic        is_add, is_sub, is_cmp, is_undef;
  logic        cond_pass, accept, ovf_trap, upd_flags;
  logic        n_f, z_f, c_f, v_f;
  logic [32:0] sum33, diff33;

  assign {n_f, z_f, c_f, v_f} = flags_q;
  assign in_ready = !out_valid_q || out_ready;
  assign accept   = in_valid && in_ready && !flush;
  assign is_cmp   = (in_opcode[3:2] == 2'b10);

  always_comb begin
    alu_in_0 = in_rn_val;
    alu_in_1 = in_op2_val;
    alu_op   = ALU_OP_NOP;
    is_add   = 1'b0;
    is_sub   = 1'b0;
    is_undef = 1'b0;
    unique case (in_opcode)
      OPC_AND, OPC_TST: alu_op = ALU_OP_AND;
      OPC_EOR, OPC_TEQ: alu_op = ALU_OP_XOR;
      OPC_ORR:          alu_op = ALU_OP_OR;
      OPC_SUB, OPC_CMP: begin
        alu_op = ALU_OP_SUBS;
        is_sub = 1'b1;
      end
      OPC_RSB: begin
        alu_in_0 = in_op2_val;
        alu_in_1 = in_rn_val;
        alu_op   = ALU_OP_SUBS;
        is_sub   = 1'b1;
      end
      OPC_ADD, OPC_CMN: begin
        alu_op = ALU_OP_ADDS;
        is_add = 1'b1;
      end
      OPC_MOV: begin
        alu_in_0 = in_op2_val;
        alu_in_1 = 32'd0;
      end
      default: is_undef = 1'b1;
    endcase
  end

  always_comb begin
    unique case (in_cond)
      4'h0:    cond_pass = z_f;
      4'h1:    cond_pass = !z_f;
      4'h2:    cond_pass = c_f;
      4'h3:    cond_pass = !c_f;
      4'h4:    cond_pass = n_f;
      4'h5:    cond_pass = !n_f;
      4'h6:    cond_pass = v_f;
      4'h7:    cond_pass = !v_f;
      4'h8:    cond_pass = c_f && !z_f;
      4'h9:    cond_pass = !c_f || z_f;
      4'ha:    cond_pass = (n_f == v_f);
      4'hb:    cond_pass = (n_f != v_f);
      4'hc:    cond_pass = !z_f && (n_f == v_f);
      4'hd:    cond_pass = z_f || (n_f != v_f);
      4'he:    cond_pass = 1'b1;
      default: cond_pass = 1'b0;
    endcase
  end

  // Carry is rebuilt locally; the ALU only reports signed overflow.
  assign sum33  = {1'b0, alu_in_0} + {1'b0, alu_in_1};
  assign diff33 = {1'b0, alu_in_0} - {1'b0, alu_in_1};

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_rd_d    = out_rd_q;
    out_wr_en_d = out_wr_en_q;
    out_undef_d = out_undef_q;
    flags_d     = flags_q;
    ovf_trap    = 1'b0;
`ifdef ALU_ISSUE_OVF_TRAP_EN
    ovf_trap    = (is_add || is_sub) && alu_of;
`else
    ovf_trap    = 1'b0;
`endif
    upd_flags   = cond_pass && !is_undef && (in_s || is_cmp);
    if (flush) begin
      out_valid_d = 1'b0;
    end else if (accept) begin
      out_valid_d = 1'b1;
      out_data_d  = alu_out;
      out_rd_d    = in_rd;
      out_undef_d = is_undef || (cond_pass && ovf_trap);
      out_wr_en_d = cond_pass && !is_undef && !is_cmp && !ovf_trap;
      if (upd_flags) begin
        flags_d[3] = alu_out[31];
        flags_d[2] = (alu_out == 32'd0);
        if (is_add) begin
          flags_d[1] = sum33[32];
          flags_d[0] = alu_of;
        end else if (is_sub) begin
          flags_d[1] = !diff33[32];
          flags_d[0] = alu_of;
        end
      end
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      out_data_q  <= 32'd0;
      out_rd_q    <= 4'd0;
      out_wr_en_q <= 1'b0;
      out_undef_q <= 1'b0;
      flags_q     <= RESET_FLAGS;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_rd_q    <= out_rd_d;
      out_wr_en_q <= out_wr_en_d;
      out_undef_q <= out_undef_d;
      flags_q     <= flags_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_rd    = out_rd_q;
  assign out_wr_en = out_wr_en_q;
  assign out_undef = out_undef_q;
  assign flags     = flags_q;

endmodule

// File: tb/tb_alu_issue.sv
// tb_alu_issue: vector table, hand sequences and random traffic
// against an ARM-semantics reference model.
module tb_alu_issue;

  localparam logic [3:0] A_NOP  = 4'd0;
  localparam logic [3:0] A_AND  = 4'd1;
  localparam logic [3:0] A_OR   = 4'd2;
  localparam logic [3:0] A_XOR  = 4'd3;
  localparam logic [3:0] A_ADDS = 4'd4;
  localparam logic [3:0] A_SUBS = 4'd5;

  logic        clk = 1'b0;
  logic        reset, flush, in_valid, in_s, out_ready;
  logic        in_ready, alu_of;
  logic [3:0]  in_cond, in_opcode, in_rd, alu_op;
  logic [31:0] in_rn_val, in_op2_val, alu_in_0, alu_in_1, alu_out;
  logic        out_valid, out_wr_en, out_undef;
  logic [31:0] out_data;
  logic [3:0]  out_rd, flags;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  alu_issue dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_cond(in_cond), .in_opcode(in_opcode), .in_s(in_s),
    .in_rd(in_rd), .in_rn_val(in_rn_val), .in_op2_val(in_op2_val),
    .alu_in_0(alu_in_0), .alu_in_1(alu_in_1), .alu_op(alu_op),
    .alu_out(alu_out), .alu_of(alu_of),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_rd(out_rd),
    .out_wr_en(out_wr_en), .out_undef(out_undef), .flags(flags)
  );

  // External ALU
  always_comb begin
    alu_out = 32'd0;
    alu_of  = 1'b0;
    case (alu_op)
      A_NOP: alu_out = alu_in_0;
      A_AND: alu_out = alu_in_0 & alu_in_1;
      A_OR:  alu_out = alu_in_0 | alu_in_1;
      A_XOR: alu_out = alu_in_0 ^ alu_in_1;
      A_ADDS: begin
        alu_out = alu_in_0 + alu_in_1;
        alu_of  = (alu_in_0[31] == alu_in_1[31]) &&
                  (alu_out[31] != alu_in_0[31]);
      end
      A_SUBS: begin
        alu_out = alu_in_0 - alu_in_1;
        alu_of  = (alu_in_0[31] != alu_in_1[31]) &&
                  (alu_out[31] != alu_in_0[31]);
      end
      default: alu_out = 32'd0;
    endcase
  end

  initial begin
    #2000000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input int idx,
                     input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s[%0d] act=%h exp=%h", nm, idx, act, exp);
    end
  endtask

  typedef struct {
    logic [31:0] data;
    logic        wr;
    logic        undef;
    logic [3:0]  flags;
  } res_t;

  function automatic res_t ref_exec(input logic [3:0] cond,
                                    input logic [3:0] opc,
                                    input logic s,
                                    input logic [31:0] rn,
                                    input logic [31:0] op2,
                                    input logic [3:0] f);
    res_t r;
    bit n = f[3], z = f[2], c = f[1], v = f[0];
    bit pass, arith = 0, undef = 0, test, nc = 0, nv = 0;
    logic [31:0] res = 32'd0;
    logic [32:0] w;
    longint sr = 0;
    case (cond)
      4'h0: pass = z;
      4'h1: pass = !z;
      4'h2: pass = c;
      4'h3: pass = !c;
      4'h4: pass = n;
      4'h5: pass = !n;
      4'h6: pass = v;
      4'h7: pass = !v;
      4'h8: pass = c && !z;
      4'h9: pass = !c || z;
      4'ha: pass = (n == v);
      4'hb: pass = (n != v);
      4'hc: pass = !z && (n == v);
      4'hd: pass = z || (n != v);
      4'he: pass = 1;
      default: pass = 0;
    endcase
    case (opc)
      4'h0, 4'h8: res = rn & op2;
      4'h1, 4'h9: res = rn ^ op2;
      4'hc:       res = rn | op2;
      4'hd:       res = op2;
      4'h2, 4'ha: begin
        res = rn - op2; arith = 1; nc = (rn >= op2);
        sr = longint'($signed(rn)) - longint'($signed(op2));
      end
      4'h3: begin
        res = op2 - rn; arith = 1; nc = (op2 >= rn);
        sr = longint'($signed(op2)) - longint'($signed(rn));
      end
      4'h4, 4'hb: begin
        w = {1'b0, rn} + {1'b0, op2};
        res = w[31:0]; arith = 1; nc = w[32];
        sr = longint'($signed(rn)) + longint'($signed(op2));
      end
      default: undef = 1;
    endcase
    if (arith) nv = (sr != longint'($signed(res)));
    test = (opc >= 4'h8) && (opc <= 4'hb);
    r.data  = res;
    r.undef = undef;
    r.wr    = pass && !undef && !test;
    r.flags = f;
    if (pass && !undef && (s || test))
      r.flags = {res[31], res == 32'd0, arith ? nc : c, arith ? nv : v};
`ifdef ALU_ISSUE_OVF_TRAP_EN
    if (pass && arith && nv) begin
      r.undef = 1;
      r.wr    = 0;
    end
`endif
    return r;
  endfunction

  typedef struct {
    logic [3:0]  cond;
    logic [3:0]  opc;
    logic        s;
    logic [3:0]  rd;
    logic [31:0] rn;
    logic [31:0] op2;
    logic [31:0] data;
    logic        wr;
    logic        undef;
    logic [3:0]  flags;
  } vec_t;

  localparam int NV = 17;
  vec_t tbl[NV];

  task automatic drive(input logic [3:0] cond, input logic [3:0] opc,
                       input logic s, input logic [3:0] rd,
                       input logic [31:0] rn, input logic [31:0] op2);
    in_valid   = 1'b1;
    in_cond    = cond;
    in_opcode  = opc;
    in_s       = s;
    in_rd      = rd;
    in_rn_val  = rn;
    in_op2_val = op2;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] rnd32();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'h7fffffff;
      2: return 32'h80000000;
      3: return 32'hffffffff;
      4: return 32'($urandom_range(0, 7));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    res_t        r, mres;
    logic        mvalid;
    logic [3:0]  mf, mrd, fexp;
    logic        acc;

    tbl[0]  = '{4'he, 4'h4, 1, 4'h1, 32'h7fffffff, 32'h1, 32'h80000000, 1, 0, 4'b1001};
    tbl[1]  = '{4'he, 4'h3, 0, 4'h2, 32'h5, 32'h3, 32'hfffffffe, 1, 0, 4'b1001};
    tbl[2]  = '{4'he, 4'ha, 1, 4'h3, 32'h4, 32'h4, 32'h0, 0, 0, 4'b0110};
    tbl[3]  = '{4'h0, 4'h4, 0, 4'h4, 32'h1, 32'h1, 32'h2, 1, 0, 4'b0110};
    tbl[4]  = '{4'h1, 4'h4, 0, 4'h5, 32'h1, 32'h1, 32'h2, 0, 0, 4'b0110};
    tbl[5]  = '{4'he, 4'hd, 1, 4'h6, 32'h1234, 32'h80000000, 32'h80000000, 1, 0, 4'b1010};
    tbl[6]  = '{4'he, 4'h5, 1, 4'h7, 32'h1, 32'h1, 32'h0, 0, 1, 4'b1010};
    tbl[7]  = '{4'he, 4'h8, 0, 4'h8, 32'hf0, 32'h0f, 32'h0, 0, 0, 4'b0110};
    tbl[8]  = '{4'he, 4'h9, 0, 4'h9, 32'h80000000, 32'h0, 32'h0, 0, 0, 4'b1010};
    tbl[9]  = '{4'he, 4'hb, 0, 4'ha, 32'hffffffff, 32'h1, 32'h0, 0, 0, 4'b0110};
    tbl[10] = '{4'he, 4'h2, 1, 4'hb, 32'h3, 32'h5, 32'hfffffffe, 1, 0, 4'b1000};
    tbl[11] = '{4'hf, 4'hc, 1, 4'hc, 32'h1, 32'h2, 32'h0, 0, 0, 4'b1000};
    tbl[12] = '{4'he, 4'h1, 1, 4'hd, 32'hff, 32'h0f, 32'hf0, 1, 0, 4'b0000};
    tbl[13] = '{4'he, 4'h2, 0, 4'he, 32'h80000000, 32'h1, 32'h7fffffff, 1, 0, 4'b0000};
    tbl[14] = '{4'he, 4'hf, 1, 4'hf, 32'h0, 32'h0, 32'h0, 0, 1, 4'b0000};
    tbl[15] = '{4'ha, 4'h4, 1, 4'h0, 32'h1, 32'h2, 32'h3, 1, 0, 4'b0000};
    tbl[16] = '{4'he, 4'he, 1, 4'h1, 32'h1, 32'h1, 32'h0, 0, 1, 4'b0000};
`ifdef ALU_ISSUE_OVF_TRAP_EN
    tbl[0].wr = 0;  tbl[0].undef = 1;
    tbl[13].wr = 0; tbl[13].undef = 1;
`endif

    reset = 1; flush = 0; out_ready = 1;
    drive(4'he, 4'h0, 0, 0, 0, 0);
    in_valid = 0;
    tick();
    tick();
    chk("rst_valid", 0, 32'(out_valid), 0);
    chk("rst_flags", 0, 32'(flags), 0);
    chk("rst_in_ready", 0, 32'(in_ready), 1);
    chk("rst_data", 0, out_data, 0);
    chk("rst_rd", 0, 32'(out_rd), 0);
    chk("rst_wr", 0, 32'(out_wr_en), 0);
    chk("rst_undef", 0, 32'(out_undef), 0);
    reset = 0;

    for (int i = 0; i < NV; i++) begin
      drive(tbl[i].cond, tbl[i].opc, tbl[i].s, tbl[i].rd,
            tbl[i].rn, tbl[i].op2);
      #1;
      chk("tbl_in_ready", i, 32'(in_ready), 1);
      if (tbl[i].opc == 4'h3) begin
        chk("rsb_alu_in_0", i, alu_in_0, tbl[i].op2);
        chk("rsb_alu_in_1", i, alu_in_1, tbl[i].rn);
        chk("rsb_alu_op", i, 32'(alu_op), 32'(A_SUBS));
      end
      tick();
      chk("tbl_valid", i, 32'(out_valid), 1);
      chk("tbl_rd", i, 32'(out_rd), 32'(tbl[i].rd));
      chk("tbl_wr", i, 32'(out_wr_en), 32'(tbl[i].wr));
      chk("tbl_undef", i, 32'(out_undef), 32'(tbl[i].undef));
      chk("tbl_flags", i, 32'(flags), 32'(tbl[i].flags));
      if (tbl[i].wr) chk("tbl_data", i, out_data, tbl[i].data);
    end
    fexp = tbl[NV-1].flags;
    in_valid = 0;
    tick();
    chk("drain_valid", 0, 32'(out_valid), 0);

    // Backpressure: result held, input stalled, then replaced with no bubble
    out_ready = 0;
    drive(4'he, 4'hd, 0, 4'h3, 32'h0, 32'ha5);
    tick();
    chk("bp_valid", 0, 32'(out_valid), 1);
    chk("bp_data", 0, out_data, 32'ha5);
    drive(4'he, 4'h4, 0, 4'h4, 32'h1, 32'h1);
    for (int k = 0; k < 3; k++) begin
      chk("bp_in_ready", k, 32'(in_ready), 0);
      tick();
      chk("bp_hold_data", k, out_data, 32'ha5);
      chk("bp_hold_rd", k, 32'(out_rd), 3);
      chk("bp_hold_valid", k, 32'(out_valid), 1);
    end
    out_ready = 1;
    #1;
    chk("bp_release_ready", 0, 32'(in_ready), 1);
    tick();
    chk("bp_next_valid", 0, 32'(out_valid), 1);
    chk("bp_next_data", 0, out_data, 32'h2);
    chk("bp_next_rd", 0, 32'(out_rd), 4);
    in_valid = 0;
    tick();
    chk("bp_drain", 0, 32'(out_valid), 0);

    // Flush drops held result and blocks acceptance and flag update
    out_ready = 0;
    drive(4'he, 4'hd, 0, 4'h5, 32'h0, 32'h55);
    tick();
    chk("fl_pre_valid", 0, 32'(out_valid), 1);
    out_ready = 1;
    flush = 1;
    drive(4'he, 4'ha, 1, 4'h6, 32'h0, 32'h1);
    tick();
    chk("fl_valid", 0, 32'(out_valid), 0);
    chk("fl_flags", 0, 32'(flags), 32'(fexp));
    flush = 0;
    in_valid = 0;

    // Reset mid-operation
    out_ready = 0;
    drive(4'he, 4'h4, 1, 4'h7, 32'hffffffff, 32'h1);
    tick();
    chk("rm_valid", 0, 32'(out_valid), 1);
    chk("rm_flags", 0, 32'(flags), 32'b0110);
    reset = 1;
    drive(4'he, 4'h2, 1, 4'h8, 32'h0, 32'h1);
    tick();
    chk("rm_after_valid", 0, 32'(out_valid), 0);
    chk("rm_after_flags", 0, 32'(flags), 0);
    chk("rm_after_wr", 0, 32'(out_wr_en), 0);
    chk("rm_after_data", 0, out_data, 0);
    reset = 0;
    in_valid = 0;
    out_ready = 1;

    // Random traffic against the reference model
    mvalid = 0;
    mf = 4'b0000;
    mrd = 0;
    mres = '{32'h0, 1'b0, 1'b0, 4'h0};
    for (int c = 0; c < 600; c++) begin
      drive(($urandom_range(0, 1) != 0) ? 4'he : 4'($urandom_range(0, 15)),
            4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
            4'($urandom_range(0, 15)), rnd32(), rnd32());
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 19) == 0);
      #1;
      chk("rnd_in_ready", c, 32'(in_ready), 32'(!mvalid || out_ready));
      acc = in_valid && (!mvalid || out_ready) && !flush;
      if (flush) begin
        mvalid = 0;
      end else if (acc) begin
        r = ref_exec(in_cond, in_opcode, in_s, in_rn_val, in_op2_val, mf);
        mvalid = 1;
        mres = r;
        mrd = in_rd;
        mf = r.flags;
      end else if (out_ready) begin
        mvalid = 0;
      end
      tick();
      chk("rnd_valid", c, 32'(out_valid), 32'(mvalid));
      chk("rnd_flags", c, 32'(flags), 32'(mf));
      if (mvalid) begin
        chk("rnd_rd", c, 32'(out_rd), 32'(mrd));
        chk("rnd_wr", c, 32'(out_wr_en), 32'(mres.wr));
        chk("rnd_undef", c, 32'(out_undef), 32'(mres.undef));
        if (mres.wr) chk("rnd_data", c, out_data, mres.data);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
